// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   op_e    : operation codes carried on the op port (MULTU, MULT, DIVU, DIV).
//   state_e : control FSM states (IDLE, RUN, FIXUP).
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10
    } state_e;

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   mode     in  : 0 = shift-add multiply, 1 = restoring divide.
//   acc      in  : partial product upper half / partial remainder (WIDTH+1 bits).
//   aux      in  : multiplier bits still to consume / dividend bits shifting in,
//                  and the growing product low half / quotient.
//   operand  in  : multiplicand or divisor magnitude.
//   acc_next out : updated accumulator.
//   aux_next out : updated aux register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] aux,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] aux_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Single iteration: conditional add + right shift, or left shift + trial subtract.
    always_comb begin
        sum_s     = {(WIDTH+1){1'b0}};
        shifted_s = {(WIDTH+1){1'b0}};
        trial_s   = {(WIDTH+2){1'b0}};
        acc_next  = acc;
        aux_next  = aux;
        if (mode == 1'b0) begin
            // The accumulator never exceeds WIDTH bits, so the sum fits in WIDTH+1.
            if (aux[0] == 1'b1) begin
                sum_s = acc + {1'b0, operand};
            end else begin
                sum_s = acc;
            end
            acc_next = {1'b0, sum_s[WIDTH:1]};
            aux_next = {sum_s[0], aux[WIDTH-1:1]};
        end else begin
            shifted_s = {acc[WIDTH-1:0], aux[WIDTH-1]};
            // Extra top bit acts as the borrow flag of the trial subtraction.
            trial_s   = {1'b0, shifted_s} - {2'b00, operand};
            if (trial_s[WIDTH+1] == 1'b0) begin
                acc_next = trial_s[WIDTH:0];
                aux_next = {aux[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted_s;
                aux_next = {aux[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset.
//   start, op           : launch request and operation code (sampled in IDLE).
//   operand_a/operand_b : rs / rt operands, latched when a start is accepted.
//   hi_we, lo_we,wr_data: MTHI/MTLO writes, honoured only while idle.
//   busy, done          : operation in progress / one-cycle completion pulse.
//   div_by_zero         : set with done for a zero divisor, held until next start.
//   hi, lo              : HI/LO registers.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_r;
    op_e                op_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   aux_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   raw_a_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               dbz_r;

    logic               mode_s;
    logic [WIDTH:0]     acc_step_s;
    logic [WIDTH-1:0]   aux_step_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    // Two's-complement magnitude for signed ops, raw bits for unsigned ops.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic is_signed);
        logic [WIDTH-1:0] result;
        if (is_signed && value[WIDTH-1]) begin
            result = -value;
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign mode_s = (op_r == OP_DIVU) || (op_r == OP_DIV);

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode     (mode_s),
        .acc      (acc_r),
        .aux      (aux_r),
        .operand  (opnd_r),
        .acc_next (acc_step_s),
        .aux_next (aux_step_s)
    );

    // Sign correction and divide-by-zero override of the final HI/LO values.
    always_comb begin
        product_s = {acc_r[WIDTH-1:0], aux_r};
        res_hi_s  = {WIDTH{1'b0}};
        res_lo_s  = {WIDTH{1'b0}};
        case (op_r)
            OP_MULTU, OP_MULT: begin
                // neg_q_r is only ever set for signed operations.
                if (neg_q_r) begin
                    product_s = -product_s;
                end else begin
                    product_s = {acc_r[WIDTH-1:0], aux_r};
                end
                res_hi_s = product_s[2*WIDTH-1:WIDTH];
                res_lo_s = product_s[WIDTH-1:0];
            end
            OP_DIVU, OP_DIV: begin
                if (dbz_r) begin
                    res_lo_s = {WIDTH{1'b1}};
                    res_hi_s = raw_a_r;
                end else begin
                    if (neg_q_r) begin
                        res_lo_s = -aux_r;
                    end else begin
                        res_lo_s = aux_r;
                    end
                    if (neg_r_r) begin
                        res_hi_s = -acc_r[WIDTH-1:0];
                    end else begin
                        res_hi_s = acc_r[WIDTH-1:0];
                    end
                end
            end
            default: begin
                res_hi_s = {WIDTH{1'b0}};
                res_lo_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Control FSM, iteration datapath registers and the HI/LO/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            op_r        <= OP_MULTU;
            count_r     <= {CNT_W{1'b0}};
            acc_r       <= {(WIDTH+1){1'b0}};
            aux_r       <= {WIDTH{1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            raw_a_r     <= {WIDTH{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (hi_we) begin
                        hi <= wr_data;
                    end
                    if (lo_we) begin
                        lo <= wr_data;
                    end
                    if (start) begin
                        op_r        <= op_e'(op);
                        aux_r       <= magnitude(operand_a, op[0]);
                        opnd_r      <= magnitude(operand_b, op[0]);
                        raw_a_r     <= operand_a;
                        neg_q_r     <= op[0] & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_r_r     <= op[0] & operand_a[WIDTH-1];
                        dbz_r       <= op[1] & (operand_b == {WIDTH{1'b0}});
                        acc_r       <= {(WIDTH+1){1'b0}};
                        count_r     <= {CNT_W{1'b0}};
                        div_by_zero <= 1'b0;
                        state_r     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // busy trails the state by one cycle so it spans RUN plus FIXUP entry.
                    busy <= 1'b1;
                    if (count_r == CNT_W'(WIDTH)) begin
                        state_r <= S_FIXUP;
                    end else begin
                        acc_r   <= acc_step_s;
                        aux_r   <= aux_step_s;
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                S_FIXUP: begin
                    hi          <= res_hi_s;
                    lo          <= res_lo_s;
                    div_by_zero <= dbz_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Sequential multiply/divide unit that extends the single-cycle MIPS datapath with MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers. It sits beside the ALU and takes the register-file Data1/Data2 values as operands. Operand width is parametrised. The unit uses a radix-2 iterative shift-add multiplier and a restoring divider, and exposes a start/busy/done handshake so the control unit can stall the PC until results land. HI/LO are also directly writable for MTHI/MTLO and are always readable for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; WIDTH >= 4.
CNT_W, $clog2(WIDTH)+1, localparam: iteration counter width; not overridable.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
op  input  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
operand_a  input  WIDTH  multiplicand or dividend (rs).
operand_b  input  WIDTH  multiplier or divisor (rt).
hi_we  input  1  MTHI write strobe.
lo_we  input  1  MTLO write strobe.
wr_data  input  WIDTH  data for MTHI/MTLO.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse in the cycle HI/LO first show new results.
div_by_zero  output  1  valid with done; high if a DIV/DIVU had operand_b=0.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset, synchronous, wins over every other input:
  - state goes to IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - An in-flight operation is discarded with no partial HI/LO update.
- FSM states: IDLE, RUN, FIXUP.
  - IDLE: start=1 at edge t latches op and operand magnitudes (absolute values for signed ops, raw values for unsigned), clears the accumulator, sets count=0, and moves to RUN. busy=1 from t+1.
  - RUN: one radix-2 iteration per cycle. After exactly WIDTH iterations, go to FIXUP.
  - FIXUP: one cycle. Applies the sign correction, writes hi/lo, sets done=1, returns to IDLE, busy=0.
- Latency: done is high and hi/lo are valid in the cycle after edge t+WIDTH+2. Busy is high for WIDTH+1 cycles.
- done is high for exactly one cycle. div_by_zero holds its value until the next start is accepted, then clears.
- start while busy=1 is ignored: no queueing and no error.
- Multiply: full 2*WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits. For MULT, the product is negated if sign(a) XOR sign(b).
- Divide:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
  - Quotient is negated if sign(a) XOR sign(b).
  - Signed most-negative / -1 wraps: lo = 1 followed by zeros, hi = 0. No flag is raised.
- Divide by zero: full latency is still taken. lo = all ones, hi = operand_a as latched (raw bits), div_by_zero=1.
- MTHI/MTLO:
  - When busy=0, hi_we/lo_we update hi/lo at the next edge.
  - When busy=1 they are ignored.
  - If hi_we/lo_we and start arrive in the same IDLE cycle, the write takes effect and the operation starts; the later FIXUP result overwrites it.
- Operands are latched at start. Later changes on operand_a/operand_b/op have no effect.

Decomposition:
- Shared package mips_muldiv_pkg:
  - op encodings OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - state encodings S_IDLE, S_RUN, S_FIXUP.
- One combinational sub-module, muldiv_step, performs a single iteration:
  - multiply: conditional add then shift right.
  - divide: shift left, trial subtract, set quotient bit.
  - A mode input selects multiply or divide.
- The FSM, counter, sign fixup and HI/LO registers stay in mips_muldiv_unit.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at edge 0 -> busy from edge 1; done at edge 34 with hi=0xFFFFFFFE, lo=0x00000001.
2. MULT 0xFFFFFFFD (-3) * 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Also DIVU 100/7 -> lo=14, hi=2.
4. DIVU 5 / 0 -> done at edge 34, div_by_zero=1, lo=0xFFFFFFFF, hi=5. The next accepted start clears div_by_zero.
5. Second start plus hi_we (wr_data=0x1234) at edge 10 of a running MULTU 2*3 -> both ignored; done at edge 34 with hi=0, lo=6.
6. Reset at edge 10 of a running DIV -> edge 11: busy=0, hi=lo=0, done never pulses. A new start at edge 12 completes normally at edge 46.
